ctba_fetch_sched: RTL and testbench

//  Schedules command-header/CTBA fetches into the per-slot command cache and arbitrates cache access.

---
 rtl/ctba_fetch_sched_pkg.sv | 15 +
 rtl/ctba_fetch_sched_if.sv | 40 ++++
 rtl/ctba_fetch_sched_rr_pick32.sv | 27 ++
 rtl/ctba_fetch_sched.sv | 125 ++++++++++++
 tb/tb_ctba_fetch_sched.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctba_fetch_sched_pkg.sv
// rtl/ctba_fetch_sched_pkg.sv - shared types and constants for the CTBA fetch scheduler
package ctba_fetch_sched_pkg;
  localparam int C_NSLOT       = 32;
  localparam int C_SLOTW       = 5;
  localparam int C_FAIRCNT_DEF = 4;

  typedef logic [C_SLOTW-1:0] slot_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PORT,
    S_PDROP
  } state_t;
endpackage

// File: rtl/ctba_fetch_sched_if.sv
// rtl/ctba_fetch_sched_if.sv - port FSM, fetch engine, cache and ready-stream signals of the scheduler
interface ctba_fetch_sched_if;
  import ctba_fetch_sched_pkg::*;

  logic [C_NSLOT-1:0] port2sched_ci;
  logic [C_NSLOT-1:0] port2sched_clr;
  logic               port2ctba_FetchCmd_req;
  slot_t              port2ctba_FetchCmd_slot;
  logic               ctba2sched_done;
  logic               ctba2sched_err;
  logic               port_req;
  slot_t              port_slot;
  logic               port_we;
  logic               port_ack;
  logic               port2cache_req;
  slot_t              port2cache_slot;
  logic               port2cache_we;
  logic               cache2port_ack;
  logic               sched_rdy_valid;
  slot_t              sched_rdy_slot;
  logic               sched_rdy_pop;
  logic               sched_fetch_err;
  slot_t              sched_err_slot;

  modport master (
    output port2sched_ci, port2sched_clr, ctba2sched_done, ctba2sched_err,
           port_req, port_slot, port_we, cache2port_ack, sched_rdy_pop,
    input  port2ctba_FetchCmd_req, port2ctba_FetchCmd_slot, port_ack,
           port2cache_req, port2cache_slot, port2cache_we,
           sched_rdy_valid, sched_rdy_slot, sched_fetch_err, sched_err_slot
  );

  modport slave (
    input  port2sched_ci, port2sched_clr, ctba2sched_done, ctba2sched_err,
           port_req, port_slot, port_we, cache2port_ack, sched_rdy_pop,
    output port2ctba_FetchCmd_req, port2ctba_FetchCmd_slot, port_ack,
           port2cache_req, port2cache_slot, port2cache_we,
           sched_rdy_valid, sched_rdy_slot, sched_fetch_err, sched_err_slot
  );
endinterface

// File: rtl/ctba_fetch_sched_rr_pick32.sv
// rtl/ctba_fetch_sched_rr_pick32.sv - 32-bit rotating priority encoder (first set bit at/after ptr)
module rr_pick32
  import ctba_fetch_sched_pkg::*;
(
  input  logic [C_NSLOT-1:0] vec,
  input  slot_t              ptr,
  output logic               valid,
  output slot_t              idx
);

  slot_t k;

  // Scan offsets from the far end down so the smallest offset from ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = C_NSLOT - 1; i >= 0; i--) begin
      k = ptr + slot_t'(i);
      if (vec[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/ctba_fetch_sched.sv
// rtl/ctba_fetch_sched.sv - schedules CTBA fetches and arbitrates the shared command-cache port
module ctba_fetch_sched
  import ctba_fetch_sched_pkg::*;
#(
  parameter int C_FAIRCNT = C_FAIRCNT_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  ctba_fetch_sched_if.slave   bus
);

  state_t             state, state_nx;
  logic [C_NSLOT-1:0] cached, ready, inflight;
  logic [C_NSLOT-1:0] cached_nx, ready_nx, inflight_nx;
  logic [C_NSLOT-1:0] live, pending, rdy_vec;
  slot_t              rr_ptr, rdy_ptr, fetch_slot, pick_slot, rdy_slot;
  slot_t              pc_slot, err_slot_q;
  logic               pc_we, err_q, fetch_kill;
  logic               pick_valid, rdy_valid;
  logic [3:0]         fair;
  logic               grant_port, start_fetch, fetch_end, commit;

  // A slot is live while issued and not being completed this cycle.
  assign live    = bus.port2sched_ci & ~bus.port2sched_clr;
  assign pending = live & ~cached & ~inflight;
  assign rdy_vec = ready & live;

  rr_pick32 u_pend_pick (.vec(pending), .ptr(rr_ptr),  .valid(pick_valid), .idx(pick_slot));
  rr_pick32 u_rdy_pick  (.vec(rdy_vec), .ptr(rdy_ptr), .valid(rdy_valid),  .idx(rdy_slot));

  // Port wins unless a fetch is waiting and the port has used up its fairness budget.
  assign grant_port  = (state == S_IDLE) && bus.port_req &&
                       (!pick_valid || (fair < 4'(C_FAIRCNT)));
  assign start_fetch = (state == S_IDLE) && !grant_port && pick_valid;
  assign fetch_end   = (state == S_FETCH) && (bus.ctba2sched_done || bus.ctba2sched_err);
  assign commit      = (state == S_FETCH) && bus.ctba2sched_done && !bus.ctba2sched_err &&
                       !fetch_kill && live[fetch_slot];

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant_port) state_nx = S_PORT;
               else if (start_fetch) state_nx = S_FETCH;
      S_FETCH: if (fetch_end) state_nx = S_IDLE;
      S_PORT:  if (bus.cache2port_ack) state_nx = S_PDROP;
      S_PDROP: if (!bus.cache2port_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state; fetch and port cache requests are mutually exclusive by state.
  always_comb begin
    bus.port2ctba_FetchCmd_req  = (state == S_FETCH);
    bus.port2ctba_FetchCmd_slot = fetch_slot;
    bus.port2cache_req          = (state == S_PORT);
    bus.port2cache_slot         = pc_slot;
    bus.port2cache_we           = pc_we;
    bus.port_ack                = (state == S_PORT) && bus.cache2port_ack;
    bus.sched_rdy_valid         = rdy_valid;
    bus.sched_rdy_slot          = rdy_slot;
    bus.sched_fetch_err         = err_q;
    bus.sched_err_slot          = err_slot_q;
  end

  // Slot bitmap updates: drop dead slots, mark fetch start/finish, consume popped slots.
  always_comb begin
    cached_nx   = cached & live;
    ready_nx    = ready & live;
    inflight_nx = inflight;
    if (rdy_valid && bus.sched_rdy_pop) ready_nx[rdy_slot] = 1'b0;
    if (start_fetch) inflight_nx[pick_slot] = 1'b1;
    if (fetch_end) inflight_nx[fetch_slot] = 1'b0;
    if (commit) begin
      cached_nx[fetch_slot] = 1'b1;
      ready_nx[fetch_slot]  = 1'b1;
    end
  end

  // Datapath registers: bitmaps, pointers, fairness counter, latched port/fetch context.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cached     <= '0;
      ready      <= '0;
      inflight   <= '0;
      rr_ptr     <= '0;
      rdy_ptr    <= '0;
      fetch_slot <= '0;
      fetch_kill <= 1'b0;
      fair       <= '0;
      pc_slot    <= '0;
      pc_we      <= 1'b0;
      err_q      <= 1'b0;
      err_slot_q <= '0;
    end else begin
      cached   <= cached_nx;
      ready    <= ready_nx;
      inflight <= inflight_nx;
      err_q    <= (state == S_FETCH) && bus.ctba2sched_err;
      if ((state == S_FETCH) && bus.ctba2sched_err) err_slot_q <= fetch_slot;
      if (grant_port) begin
        pc_slot <= bus.port_slot;
        pc_we   <= bus.port_we;
        if (pick_valid) fair <= fair + 4'd1;
      end
      if (start_fetch) begin
        fetch_slot <= pick_slot;
        fetch_kill <= 1'b0;
        fair       <= '0;
      end else if ((state == S_FETCH) && !live[fetch_slot]) begin
        fetch_kill <= 1'b1;
      end
      if ((state == S_FETCH) && bus.ctba2sched_done && !bus.ctba2sched_err)
        rr_ptr <= fetch_slot + 5'd1;
      if (rdy_valid && bus.sched_rdy_pop) rdy_ptr <= rdy_slot + 5'd1;
    end
  end

endmodule

// File: tb/tb_ctba_fetch_sched.sv
// tb/tb_ctba_fetch_sched.sv - directed table-driven bench for ctba_fetch_sched
module tb_ctba_fetch_sched;
  import ctba_fetch_sched_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  ctba_fetch_sched_if bus();

  ctba_fetch_sched #(.C_FAIRCNT(4)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0]      ci;
    logic [2:0]       n;
    logic [3:0][4:0]  s;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;
  int   grants;

  // Fetch request and cache request must never be high together.
  always @(negedge sys_clk)
    if (bus.port2ctba_FetchCmd_req && bus.port2cache_req) overlap++;

  function automatic vec_t mk(logic [31:0] ci, int n, int a, int b, int c, int d);
    vec_t v;
    v.ci   = ci;
    v.n    = 3'(n);
    v.s[0] = 5'(a);
    v.s[1] = 5'(b);
    v.s[2] = 5'(c);
    v.s[3] = 5'(d);
    return v;
  endfunction

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst                 = 1'b1;
    bus.port2sched_ci       = '0;
    bus.port2sched_clr      = '0;
    bus.ctba2sched_done     = 1'b0;
    bus.ctba2sched_err      = 1'b0;
    bus.port_req            = 1'b0;
    bus.port_slot           = '0;
    bus.port_we             = 1'b0;
    bus.cache2port_ack      = 1'b0;
    bus.sched_rdy_pop       = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic do_fetch(input logic [4:0] exp, input string nm);
    int k = 0;
    while (!bus.port2ctba_FetchCmd_req && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    chk(32'(bus.port2ctba_FetchCmd_req), 1, {nm, "_req"});
    chk(32'(bus.port2ctba_FetchCmd_slot), 32'(exp), {nm, "_slot"});
    @(negedge sys_clk);
    bus.ctba2sched_done = 1'b1;
    @(negedge sys_clk);
    bus.ctba2sched_done = 1'b0;
  endtask

  task automatic pop_chk(input logic [4:0] exp, input string nm);
    chk(32'(bus.sched_rdy_valid), 1, {nm, "_valid"});
    chk(32'(bus.sched_rdy_slot), 32'(exp), {nm, "_slot"});
    bus.sched_rdy_pop = 1'b1;
    @(negedge sys_clk);
    bus.sched_rdy_pop = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(32'h0000_0005, 2, 0, 2, 0, 0);
    vecs[1] = mk(32'h8000_0001, 2, 0, 31, 0, 0);
    vecs[2] = mk(32'h0001_0100, 2, 8, 16, 0, 0);
    vecs[3] = mk(32'h0000_000E, 3, 1, 2, 3, 0);

    // Table: fetch order from reset pointer, then ready order on pops.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      chk(32'(bus.port2ctba_FetchCmd_req), 0, "rst_fetch_req");
      chk(32'(bus.port2cache_req), 0, "rst_cache_req");
      chk(32'(bus.sched_rdy_valid), 0, "rst_rdy_valid");
      chk(32'(bus.sched_fetch_err), 0, "rst_err");
      bus.port2sched_ci = vecs[i].ci;
      @(negedge sys_clk);
      chk(32'(bus.port2ctba_FetchCmd_req), 1, "start_latency");
      for (int j = 0; j < int'(vecs[i].n); j++) do_fetch(vecs[i].s[j], "vec_fetch");
      for (int j = 0; j < int'(vecs[i].n); j++) pop_chk(vecs[i].s[j], "vec_pop");
      chk(32'(bus.sched_rdy_valid), 0, "vec_drained");
    end

    // Port request held during a fetch waits for done, then PDROP blocks fetch until ack drops.
    do_reset();
    bus.port2sched_ci = 32'h0000_0008;
    @(negedge sys_clk);
    chk(32'(bus.port2ctba_FetchCmd_slot), 3, "hold_fetch_slot");
    bus.port_req  = 1'b1;
    bus.port_slot = 5'd5;
    bus.port_we   = 1'b1;
    grants = 0;
    repeat (3) begin
      @(negedge sys_clk);
      if (bus.port2cache_req) grants++;
    end
    chk(32'(grants), 0, "hold_no_port_during_fetch");
    bus.ctba2sched_done = 1'b1;
    @(negedge sys_clk);
    bus.ctba2sched_done = 1'b0;
    chk(32'(bus.port2cache_req), 0, "hold_done_first");
    @(negedge sys_clk);
    chk(32'(bus.port2cache_req), 1, "hold_port_granted");
    chk(32'(bus.port2cache_slot), 5, "hold_port_slot");
    chk(32'(bus.port2cache_we), 1, "hold_port_we");
    bus.cache2port_ack = 1'b1;
    #1;
    chk(32'(bus.port_ack), 1, "hold_port_ack");
    @(negedge sys_clk);
    chk(32'(bus.port2cache_req), 0, "pdrop_req_low");
    chk(32'(bus.port_ack), 0, "pdrop_ack_low");
    bus.port_req      = 1'b0;
    bus.port2sched_ci = 32'h0000_0018;
    @(negedge sys_clk);
    chk(32'(bus.port2ctba_FetchCmd_req), 0, "pdrop_blocks_fetch");
    bus.cache2port_ack = 1'b0;
    do_fetch(5'd4, "after_pdrop");

    // Fairness: back-to-back port requests yield to a pending fetch after 4 grants.
    do_reset();
    bus.port_req      = 1'b1;
    bus.port_slot     = 5'd2;
    bus.port2sched_ci = 32'h0000_0003;
    grants = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge sys_clk);
      if (bus.port2ctba_FetchCmd_req) break;
      if (bus.port2cache_req) begin
        grants++;
        bus.cache2port_ack = 1'b1;
      end else begin
        bus.cache2port_ack = 1'b0;
      end
    end
    chk(32'(grants), 4, "fair_grants");
    chk(32'(bus.port2ctba_FetchCmd_req), 1, "fair_fetch_forced");
    bus.port_req = 1'b0;
    do_fetch(5'd0, "fair_f0");
    do_fetch(5'd1, "fair_f1");

    // clr of the in-flight slot discards its result; slot stays uncached and is refetched.
    do_reset();
    bus.port2sched_ci = 32'h0000_0080;
    @(negedge sys_clk);
    chk(32'(bus.port2ctba_FetchCmd_slot), 7, "clr_fetch_slot");
    bus.port2sched_clr = 32'h0000_0080;
    @(negedge sys_clk);
    bus.port2sched_clr = '0;
    bus.ctba2sched_done = 1'b1;
    @(negedge sys_clk);
    bus.ctba2sched_done = 1'b0;
    chk(32'(bus.sched_rdy_valid), 0, "clr_no_ready");
    do_fetch(5'd7, "clr_refetch");
    pop_chk(5'd7, "clr_refetch_rdy");

    // Fetch error: pulse with slot, no ready, slot picked again.
    do_reset();
    bus.port2sched_ci = 32'h0000_0200;
    @(negedge sys_clk);
    chk(32'(bus.port2ctba_FetchCmd_slot), 9, "err_fetch_slot");
    bus.ctba2sched_err = 1'b1;
    @(negedge sys_clk);
    bus.ctba2sched_err = 1'b0;
    chk(32'(bus.sched_fetch_err), 1, "err_pulse");
    chk(32'(bus.sched_err_slot), 9, "err_slot");
    chk(32'(bus.sched_rdy_valid), 0, "err_no_ready");
    @(negedge sys_clk);
    chk(32'(bus.sched_fetch_err), 0, "err_pulse_one_cycle");
    do_fetch(5'd9, "err_refetch");
    pop_chk(5'd9, "err_refetch_rdy");

    // Pointer wrap: rr=31 after fetching slot 30, so 31 goes before 0.
    do_reset();
    bus.port2sched_ci = 32'h4000_0000;
    do_fetch(5'd30, "wrap_f30");
    bus.port2sched_ci = 32'hC000_0001;
    do_fetch(5'd31, "wrap_f31");
    do_fetch(5'd0, "wrap_f0");
    pop_chk(5'd0, "wrap_pop0");
    pop_chk(5'd30, "wrap_pop30");
    pop_chk(5'd31, "wrap_pop31");

    // Reset in the middle of a fetch drops everything on the next edge.
    bus.port2sched_ci = '0;
    @(negedge sys_clk);
    bus.port2sched_ci = 32'h0000_0002;
    @(negedge sys_clk);
    chk(32'(bus.port2ctba_FetchCmd_req), 1, "midrst_fetching");
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk(32'(bus.port2ctba_FetchCmd_req), 0, "midrst_req");
    chk(32'(bus.port2ctba_FetchCmd_slot), 0, "midrst_slot");
    chk(32'(bus.port2cache_req), 0, "midrst_cache_req");
    chk(32'(bus.sched_rdy_valid), 0, "midrst_rdy");
    sys_rst = 1'b0;

    chk(32'(overlap), 0, "no_overlap");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
